// File: rtl/alu_hs_if.sv
// alu_hs_if: request/response handshake bundle between a sequencer and alu_hs.
// Latency: none, wires only.
// Backpressure: req_ready stalls the requester; rsp_ready stalls the ALU in DONE.
interface alu_hs_if #(
  parameter int WIDTH = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;

  // Requester / response consumer side.
  modport master (
    output req_valid, A, B, op, rsp_ready,
    input  req_ready, rsp_valid, result, carry, zero
  );

  // ALU side.
  modport slave (
    input  req_valid, A, B, op, rsp_ready,
    output req_ready, rsp_valid, result, carry, zero
  );
endinterface

// File: rtl/alu_hs.sv
// alu_hs: registered ALU behind req/rsp valid-ready handshakes; ALU_MUL_EN adds an iterative shift-add multiplier on op 111.
// Latency: single-cycle ops respond one edge after accept; multiply responds WIDTH+1 edges after accept.
// Backpressure: one op in flight; req_ready low from accept until the response handshake, DONE held while rsp_ready low.
module alu_hs #(
  parameter int WIDTH = 4
) (
  input logic   clk,
  input logic   rst,
  alu_hs_if.slave bus
);

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             rsp_hs;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cy;

`ifdef ALU_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand;  // captured multiplicand
  logic [2*WIDTH-1:0] acc;    // {partial product, remaining multiplier bits}
  logic [CW-1:0]      cnt;
  logic               fin;    // all WIDTH steps done, publish on next edge
  logic [WIDTH:0]     psum;

  assign psum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
`endif

  // rst is folded in so nothing is accepted during a reset cycle.
  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = (state == DONE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign rsp_hs        = bus.rsp_valid && bus.rsp_ready;

  // Single-cycle ops evaluated from the operands presented at the accept edge.
  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_cy  = 1'b0;
    case (bus.op)
      3'b000: begin
        ext     = {1'b0, bus.A} + {1'b0, bus.B};
        alu_res = ext[WIDTH-1:0];
        alu_cy  = ext[WIDTH];
      end
      3'b001: begin
        ext     = {1'b0, bus.A} - {1'b0, bus.B};
        alu_res = ext[WIDTH-1:0];
        alu_cy  = ext[WIDTH];  // wraps to 1 exactly when A < B
      end
      3'b010: alu_res = bus.A & bus.B;
      3'b011: alu_res = bus.A | bus.B;
      3'b100: alu_res = bus.A ^ bus.B;
      3'b101: begin
        alu_res = {bus.A[WIDTH-2:0], 1'b0};
        alu_cy  = bus.A[WIDTH-1];
      end
      3'b110: begin
        alu_res = {1'b0, bus.A[WIDTH-1:1]};
        alu_cy  = bus.A[0];
      end
      default: ;  // op 111 without the multiplier: result 0, carry 0
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          state_nxt = (bus.op == 3'b111) ? BUSY : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef ALU_MUL_EN
      BUSY:    if (fin) state_nxt = DONE;
`endif
      DONE:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output registers and multiplier datapath; outputs only change on accept or multiply completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result <= '0;
      bus.carry  <= 1'b0;
      bus.zero   <= 1'b0;
`ifdef ALU_MUL_EN
      mcand      <= '0;
      acc        <= '0;
      cnt        <= '0;
      fin        <= 1'b0;
`endif
    end else begin
      if (accept) begin
`ifdef ALU_MUL_EN
        if (bus.op == 3'b111) begin
          mcand <= bus.A;
          acc   <= {{WIDTH{1'b0}}, bus.B};
          cnt   <= '0;
          fin   <= 1'b0;
        end else
`endif
        begin
          bus.result <= alu_res;
          bus.carry  <= alu_cy;
          bus.zero   <= (alu_res == '0);
        end
      end
`ifdef ALU_MUL_EN
      if (state == BUSY) begin
        if (!fin) begin
          acc <= {psum, acc[WIDTH-1:1]};
          if (cnt == CNT_LAST) fin <= 1'b1;
          else                 cnt <= cnt + 1'b1;
        end else begin
          bus.result <= acc[WIDTH-1:0];
          bus.carry  <= |acc[2*WIDTH-1:WIDTH];
          bus.zero   <= ~|acc[WIDTH-1:0];
          fin        <= 1'b0;
          cnt        <= '0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_hs.sv
// tb_alu_hs: directed scoreboard bench for alu_hs (default build, or with ALU_MUL_EN defined).
// Latency: checks response latency per op against the model.
// Backpressure: holds rsp_ready low to check DONE stability and req_ready gating.
module tb_alu_hs;
  localparam int W = 4;

  typedef struct {
    logic [3:0] res;
    logic       cy;
    logic       z;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_hs_if #(.WIDTH(W)) bus ();
  alu_hs #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] o);
    exp_t e;
    int   s;
    e.res = 4'd0;
    e.cy  = 1'b0;
    e.lat = 1;
    s     = 0;
    case (o)
      3'd0: begin s = int'(a) + int'(b); e.res = 4'(s); e.cy = (s > 15); end
      3'd1: begin s = int'(a) - int'(b); e.res = 4'(s); e.cy = (a < b); end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: begin e.res = 4'(int'(a) * 2); e.cy = (a >= 4'd8); end
      3'd6: begin e.res = a / 4'd2; e.cy = (a % 4'd2) != 0; end
      default: begin
`ifdef ALU_MUL_EN
        s = int'(a) * int'(b);
        e.res = 4'(s);
        e.cy  = (s > 15);
        e.lat = W + 1;
`endif
      end
    endcase
    e.z = (e.res == 4'd0);
    return e;
  endfunction

  // Present one request at a negedge, hold it through the accept edge, then scramble the inputs.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] o);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before_send", {7'd0, bus.req_ready}, 8'd1);
    bus.A = a;
    bus.B = b;
    bus.op = o;
    bus.req_valid = 1'b1;
    sb.push_back(model(a, b, o));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.A  = 4'($urandom);
    bus.B  = 4'($urandom);
    bus.op = 3'($urandom);
    @(negedge clk);
  endtask

  // Wait for the response, compare with the scoreboard, optionally backpressure, then handshake.
  task automatic recv(input int hold);
    exp_t e;
    int   lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.rsp_valid !== 1'b1 && lat < 20);
    chk("rsp_valid", {7'd0, bus.rsp_valid}, 8'd1);
    chk("sb_nonempty", 8'(sb.size() != 0), 8'd1);
    if (sb.size() != 0) e = sb.pop_front();
    else e = '{res: 4'd0, cy: 1'b0, z: 1'b0, lat: 0};
    chk("latency", 8'(lat), 8'(e.lat));
    chk("result", {4'd0, bus.result}, {4'd0, e.res});
    chk("carry", {7'd0, bus.carry}, {7'd0, e.cy});
    chk("zero", {7'd0, bus.zero}, {7'd0, e.z});
    chk("req_ready_in_done", {7'd0, bus.req_ready}, 8'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {7'd0, bus.rsp_valid}, 8'd1);
      chk("bp_result", {4'd0, bus.result}, {4'd0, e.res});
      chk("bp_carry", {7'd0, bus.carry}, {7'd0, e.cy});
      chk("bp_zero", {7'd0, bus.zero}, {7'd0, e.z});
      chk("bp_req_ready", {7'd0, bus.req_ready}, 8'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("post_rsp_valid", {7'd0, bus.rsp_valid}, 8'd0);
    chk("post_req_ready", {7'd0, bus.req_ready}, 8'd1);
    chk("post_result", {4'd0, bus.result}, {4'd0, e.res});
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    bus.req_valid = 1'b1;  // must be ignored while in reset
    bus.A = 4'd3;
    bus.B = 4'd4;
    bus.op = 3'd0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", {7'd0, bus.rsp_valid}, 8'd0);
    chk("rst_result", {4'd0, bus.result}, 8'd0);
    chk("rst_carry", {7'd0, bus.carry}, 8'd0);
    chk("rst_zero", {7'd0, bus.zero}, 8'd0);
    chk("rst_req_ready", {7'd0, bus.req_ready}, 8'd0);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("req_ready_after_rst", {7'd0, bus.req_ready}, 8'd1);
    @(negedge clk);
    chk("idle_rsp_valid", {7'd0, bus.rsp_valid}, 8'd0);

    send(4'b0010, 4'b0001, 3'b000); recv(0);  // add
    send(4'b1010, 4'b1100, 3'b010); recv(0);  // and
    send(4'b1111, 4'b0001, 3'b000); recv(0);  // add wrap, carry + zero
    send(4'b0011, 4'b0101, 3'b001); recv(0);  // sub borrow
    send(4'b1001, 4'b0000, 3'b101); recv(0);  // shl
    send(4'b1001, 4'b0000, 3'b110); recv(0);  // shr
    send(4'b1010, 4'b0101, 3'b011); recv(0);  // or
    send(4'b1010, 4'b1111, 3'b100); recv(0);  // xor
    send(4'b0011, 4'b0101, 3'b111); recv(0);  // mul 3*5 (0 without multiplier)
    send(4'b0100, 4'b0100, 3'b111); recv(0);  // mul 4*4 overflow
    send(4'b0110, 4'b0011, 3'b000); recv(3);  // backpressure on add

`ifdef ALU_MUL_EN
    // Abort a multiply two cycles after accept.
    send(4'b0011, 4'b0101, 3'b111);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_mul_rsp_valid", {7'd0, bus.rsp_valid}, 8'd0);
    chk("abort_mul_result", {4'd0, bus.result}, 8'd0);
    chk("abort_mul_req_ready", {7'd0, bus.req_ready}, 8'd0);
    sb.delete();
    rst = 1'b0;
    seen = 1'b0;
    repeat (7) begin
      @(negedge clk);
      seen = seen | bus.rsp_valid;
    end
    chk("abort_mul_no_rsp", {7'd0, seen}, 8'd0);
    send(4'b0101, 4'b0010, 3'b000); recv(0);
`endif

    // Abort while a response sits in DONE.
    send(4'b0111, 4'b0001, 3'b000);
    @(negedge clk);
    chk("abort_done_rsp_valid_pre", {7'd0, bus.rsp_valid}, 8'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_done_rsp_valid", {7'd0, bus.rsp_valid}, 8'd0);
    chk("abort_done_result", {4'd0, bus.result}, 8'd0);
    chk("abort_done_carry", {7'd0, bus.carry}, 8'd0);
    chk("abort_done_req_ready", {7'd0, bus.req_ready}, 8'd0);
    sb.delete();
    rst = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | bus.rsp_valid;
    end
    chk("abort_done_no_rsp", {7'd0, seen}, 8'd0);
    send(4'b0100, 4'b0011, 3'b001); recv(0);  // sub after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
